// File: rtl/keypad_scan_ctrl.sv
// Sequenced 4x4 keypad scanner: one-cold column drive, synchronized rows,
// tick-based press/release debounce and a single-entry key buffer with ack.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV  = 10000,
  parameter int DEB_COUNT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_COUNT - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_COUNT);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      row_meta, row_s;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [1:0]      col_idx, col_nxt;
  logic [1:0]      row_idx, row_nxt;
  logic [DW-1:0]   deb_cnt, deb_nxt;
  logic            emit;

  assign tick      = (tick_cnt == TICK_LAST);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_s    <= 4'b1111;
      tick_cnt <= '0;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  // Decisions happen only on a tick; every other cycle holds all state.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    deb_nxt   = deb_cnt;
    emit      = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row_s != 4'b1111) begin
            if (!row_s[0])      row_nxt = 2'd0;
            else if (!row_s[1]) row_nxt = 2'd1;
            else if (!row_s[2]) row_nxt = 2'd2;
            else                row_nxt = 2'd3;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!row_s[row_idx]) begin
            if (deb_cnt != DEB_MAX) deb_nxt = deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
              emit      = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          if (row_s[row_idx]) begin
            deb_nxt   = '0;
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (row_s[row_idx]) begin
            if (deb_cnt != DEB_MAX) deb_nxt = deb_cnt + 1'b1;
            if (deb_cnt == DEB_LAST) begin
              col_nxt   = col_idx + 2'd1;
              state_nxt = SCAN;
            end
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      deb_cnt  <= '0;
      col_out  <= 4'b1110;
      key_down <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_nxt;
      row_idx  <= row_nxt;
      deb_cnt  <= deb_nxt;
      col_out  <= ~(4'b0001 << col_nxt);
      key_down <= (state_nxt == HELD) || (state_nxt == RELEASE);
    end
  end

  // Handshake: key_valid marks an unconsumed key_code; a cycle with
  // key_valid && key_ack consumes it. An emit while a key is pending and not
  // being consumed is dropped and flagged on overrun until the next consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit) begin
        if (!key_valid || key_ack) begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
      if (emit && key_valid && !key_ack) overrun <= 1'b1;
      else if (key_valid && key_ack)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEB_COUNT=3; all timing
// is counted in clock edges from a column-start tick.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEB_COUNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, col_out, 4'b1110);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_down"}, key_down, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
    check({tag, "_fsm"}, fsm_state, 2'd0);
  endtask

  task automatic check_next_key(input string tag);
    logic [3:0] exp_code;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 8'd0, 8'd1);
    end else begin
      exp_code = exp_q.pop_front();
      check({tag, "_code"}, key_code, exp_code);
      check({tag, "_valid"}, key_valid, 1'b1);
    end
  endtask

  initial begin
    logic [3:0] exp_col;
    int guard;

    // expected accepted keys in order: r2c1, r1c3, r0c1, r3c2
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'hE);

    rst     = 1'b1;
    row_in  = 4'b1111;
    key_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // idle scan: each column held 4 cycles
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", col_out, exp_col);
      if (k % 5 == 0) begin
        check("idle_valid", key_valid, 1'b0);
        check("idle_down", key_down, 1'b0);
      end
    end

    // align to the start of column 1
    guard = 0;
    while (col_out != 4'b1101 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("align_col1_timeout", (guard < 40) ? 8'd1 : 8'd0, 8'd1);

    // clean press row 2 / col 1
    row_in = 4'b1011;
    cycles(8);
    check("press_col_frozen", col_out, 4'b1101);
    cycles(7);
    check("press_valid_early", key_valid, 1'b0);
    check("press_down_deb", key_down, 1'b0);
    cycles(1);
    check_next_key("press");
    check("press_down", key_down, 1'b1);
    check("press_col", col_out, 4'b1101);
    cycles(24);
    check("hold_col", col_out, 4'b1101);
    check("hold_down", key_down, 1'b1);
    check("hold_fsm", fsm_state, 2'd2);

    key_ack = 1'b1;
    cycles(1);
    key_ack = 1'b0;
    check("ack_valid", key_valid, 1'b0);
    check("ack_code_kept", key_code, 4'h9);

    // release with a one-tick bounce
    row_in = 4'b1111;
    cycles(3);
    check("rel_fsm", fsm_state, 2'd3);
    check("rel_down", key_down, 1'b1);
    row_in = 4'b1011;
    cycles(4);
    check("bounce_fsm_held", fsm_state, 2'd2);
    row_in = 4'b1111;
    cycles(15);
    check("rel_down_late", key_down, 1'b1);
    cycles(1);
    check("rel_down_fall", key_down, 1'b0);
    check("rel_col2", col_out, 4'b1011);
    check("rel_no_second", key_valid, 1'b0);

    // short press bounce on row 0
    row_in = 4'b1110;
    cycles(4);
    check("bounce_col_frozen", col_out, 4'b1011);
    check("bounce_fsm_deb", fsm_state, 2'd1);
    cycles(1);
    row_in = 4'b1111;
    cycles(3);
    check("bounce_col_adv", col_out, 4'b0111);
    check("bounce_valid", key_valid, 1'b0);
    check("bounce_fsm_scan", fsm_state, 2'd0);

    // two presses without ack
    row_in = 4'b1101;
    cycles(16);
    check_next_key("first");
    row_in = 4'b1111;
    cycles(16);
    check("first_rel_col0", col_out, 4'b1110);
    check("first_rel_down", key_down, 1'b0);
    row_in = 4'b0111;
    cycles(16);
    check("ovr_code_kept", key_code, 4'h7);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    key_ack = 1'b1;
    row_in  = 4'b1111;
    cycles(1);
    key_ack = 1'b0;
    check("ovr_ack_valid", key_valid, 1'b0);
    check("ovr_ack_clear", overrun, 1'b0);
    cycles(15);
    check("ovr_rel_col1", col_out, 4'b1101);

    // ack landing on the emit cycle
    row_in = 4'b1110;
    cycles(16);
    check_next_key("pre_ack");
    row_in = 4'b1111;
    cycles(16);
    check("pre_ack_col2", col_out, 4'b1011);
    row_in = 4'b0111;
    cycles(15);
    key_ack = 1'b1;
    cycles(1);
    key_ack = 1'b0;
    check_next_key("emit_ack");
    check("emit_ack_ovr", overrun, 1'b0);
    check("emit_ack_down", key_down, 1'b1);

    // reset while HELD
    rst    = 1'b1;
    row_in = 4'b1111;
    cycles(1);
    check_reset_outputs("rst_held");

    // reset while DEBOUNCE
    rst    = 1'b0;
    row_in = 4'b1101;
    cycles(4);
    check("pre_rst_deb_fsm", fsm_state, 2'd1);
    cycles(1);
    rst    = 1'b1;
    row_in = 4'b1111;
    cycles(1);
    check_reset_outputs("rst_deb");
    rst = 1'b0;
    cycles(30);
    check("post_rst_valid", key_valid, 1'b0);
    check("post_rst_down", key_down, 1'b0);
    check("exp_q_drained", exp_q.size(), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
